femto_bus_fabric: RTL and testbench

//  Parametrised memory-map fabric between the FemtoRV32 core and N slaves (SPI flash, SPI RAM, UART, ...).

---
 rtl/femto_bus_fabric.sv | 217 +++++++++++++++++++++
 tb/tb_femto_bus_fabric.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/femto_bus_fabric.sv
// femto_bus_fabric
//   Memory-map fabric between the FemtoRV32 core and N_SLAVES slave channels.
//   cpu_addr[31:16] is decoded against PAGE_MAP to produce zero-latency per-slave
//   rd/wr strobes. The busy line of the transaction in flight is tracked by a
//   watchdog. A slave that stays busy for TIMEOUT_CYCLES is aborted: a read
//   returns ERR_DATA and the fault is logged in the status registers at ERR_PAGE.
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   cpu_addr/rstrb/wmask  core request (byte address, read strobe, write mask)
//   cpu_rdata/rbusy/wbusy core response
//   slv_rd/slv_wr         per-slave strobes (one-hot or zero)
//   slv_rdata/rbusy/wbusy per-slave response, slave i data on [32*i+31:32*i]
//   bus_err               sticky first-error flag (ERR_STATUS.valid)
module femto_bus_fabric #(
  parameter int                     N_SLAVES       = 8,
  parameter logic [N_SLAVES*16-1:0] PAGE_MAP       = {16'h0007, 16'h0006, 16'h0005, 16'h0004,
                                                      16'h0003, 16'h0002, 16'h0001, 16'h0000},
  parameter int                     DEFAULT_SLAVE  = 0,
  parameter logic [15:0]            ERR_PAGE       = 16'h00FF,
  parameter logic [31:0]            ERR_DATA       = 32'hDEADBEEF,
  parameter int                     TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              cpu_addr,
  input  logic                     cpu_rstrb,
  input  logic [3:0]               cpu_wmask,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_rbusy,
  output logic                     cpu_wbusy,
  output logic [N_SLAVES-1:0]      slv_rd,
  output logic [N_SLAVES-1:0]      slv_wr,
  input  logic [32*N_SLAVES-1:0]   slv_rdata,
  input  logic [N_SLAVES-1:0]      slv_rbusy,
  input  logic [N_SLAVES-1:0]      slv_wbusy,
  output logic                     bus_err
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [SEL_W-1:0]    DEF_SEL  = SEL_W'(DEFAULT_SLAVE);
  localparam logic [N_SLAVES-1:0] ONE_HOT0 = N_SLAVES'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, ABORT = 2'd3} state_t;

  state_t            state, state_nx;
  logic [SEL_W-1:0]  sel, rsel_q, wsel_q;
  logic [CNT_W-1:0]  cnt;
  logic              is_int, trk_busy, can_accept;
  logic              rd_acc, wr_acc, rd_slv, wr_slv;
  logic              txn_rd;        // transaction in flight is a read
  logic              int_sel;       // cpu_rdata shows the last internal register read
  logic [31:0]       int_rdata, err_rdata;
  logic              err_valid, err_was_write;
  logic [31:0]       err_addr, err_count_ext;
  logic [15:0]       err_count;

  // Page decode: lowest matching slave wins, default slave otherwise
  always_comb begin
    sel = DEF_SEL;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      sel = (PAGE_MAP[16*i +: 16] == cpu_addr[31:16]) ? SEL_W'(i) : sel;
    end
    is_int = (cpu_addr[31:16] == ERR_PAGE);
  end

  // Acceptance: idle, or the tracked busy has dropped; write beats read
  always_comb begin
    if (state == RD) begin
      trk_busy = slv_rbusy[rsel_q];
    end else if (state == WR) begin
      trk_busy = slv_wbusy[wsel_q];
    end else begin
      trk_busy = 1'b0;
    end
    can_accept = !reset && ((state == IDLE) || (((state == RD) || (state == WR)) && !trk_busy));
    wr_acc     = can_accept && (|cpu_wmask);
    rd_acc     = can_accept && cpu_rstrb && !(|cpu_wmask);
    wr_slv     = wr_acc && !is_int;
    rd_slv     = rd_acc && !is_int;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RD, WR: begin
        if (trk_busy) begin
          if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
            state_nx = ABORT;
          end else begin
            state_nx = state;
          end
        end else if (wr_slv) begin
          state_nx = WR;
        end else if (rd_slv) begin
          state_nx = RD;
        end else begin
          state_nx = IDLE;
        end
      end
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: strobes, tracked busy and read-data mux
  always_comb begin
    slv_rd = rd_slv ? (ONE_HOT0 << sel) : '0;
    slv_wr = wr_slv ? (ONE_HOT0 << sel) : '0;
    if (reset) begin
      cpu_rbusy = 1'b0;
    end else if (rd_slv) begin
      cpu_rbusy = slv_rbusy[sel];
    end else if (state == RD) begin
      cpu_rbusy = slv_rbusy[rsel_q];
    end else begin
      cpu_rbusy = 1'b0;
    end
    if (reset) begin
      cpu_wbusy = 1'b0;
    end else if (wr_slv) begin
      cpu_wbusy = slv_wbusy[sel];
    end else if (state == WR) begin
      cpu_wbusy = slv_wbusy[wsel_q];
    end else begin
      cpu_wbusy = 1'b0;
    end
    if ((state == ABORT) && txn_rd) begin
      cpu_rdata = ERR_DATA;
    end else if (int_sel) begin
      cpu_rdata = int_rdata;
    end else begin
      cpu_rdata = slv_rdata[32*int'(rsel_q) +: 32];
    end
    bus_err = err_valid;
  end

  // Internal register read mux, offset cpu_addr[3:2]
  always_comb begin
    err_count_ext = {16'h0000, err_count};
    case (cpu_addr[3:2])
      2'd0:    err_rdata = {30'd0, err_was_write, err_valid};
      2'd1:    err_rdata = err_addr;
      2'd2:    err_rdata = err_count_ext;
      default: err_rdata = 32'd0;
    endcase
  end

  // Transaction tracking: selects, watchdog counter, captured address
  logic [31:0] txn_addr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsel_q    <= DEF_SEL;
      wsel_q    <= DEF_SEL;
      cnt       <= '0;
      txn_rd    <= 1'b0;
      txn_addr  <= 32'd0;
      int_sel   <= 1'b0;
      int_rdata <= 32'd0;
    end else begin
      if (rd_slv) begin
        rsel_q <= sel;
      end
      if (wr_slv) begin
        wsel_q <= sel;
      end
      if (rd_slv || wr_slv) begin
        cnt      <= '0;
        txn_rd   <= rd_slv;
        txn_addr <= cpu_addr;
      end else if (((state == RD) || (state == WR)) && trk_busy) begin
        cnt <= cnt + CNT_W'(1);
      end
      // rsel_q stays put across internal reads, so a flag picks the data source
      if (rd_slv) begin
        int_sel <= 1'b0;
      end else if (rd_acc && is_int) begin
        int_sel   <= 1'b1;
        int_rdata <= err_rdata;
      end
    end
  end

  // Error log: abort takes priority over a clearing write to offset 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid     <= 1'b0;
      err_was_write <= 1'b0;
      err_addr      <= 32'd0;
      err_count     <= 16'd0;
    end else if (state == ABORT) begin
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
      if (!err_valid) begin
        err_valid     <= 1'b1;
        err_was_write <= !txn_rd;
        err_addr      <= txn_addr;
      end
    end else if (wr_acc && is_int && (cpu_addr[3:2] == 2'd0)) begin
      err_valid     <= 1'b0;
      err_was_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_femto_bus_fabric.sv
// Directed bench for femto_bus_fabric: a per-cycle vector table for decode,
// strobes, busy and read-data, plus sequences for timeout, error log and reset.
module tb_femto_bus_fabric;
  localparam int N = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       cpu_addr;
  logic              cpu_rstrb;
  logic [3:0]        cpu_wmask;
  logic [31:0]       cpu_rdata;
  logic              cpu_rbusy, cpu_wbusy, bus_err;
  logic [N-1:0]      slv_rd, slv_wr, slv_rbusy, slv_wbusy;
  logic [32*N-1:0]   slv_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  femto_bus_fabric #(
    .N_SLAVES(8),
    .PAGE_MAP({16'h0007, 16'h0001, 16'h0005, 16'h0006, 16'h0004, 16'h0003, 16'h0002, 16'h0000}),
    .DEFAULT_SLAVE(0),
    .ERR_PAGE(16'h00FF),
    .ERR_DATA(32'hDEADBEEF),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_rstrb(cpu_rstrb),
    .cpu_wmask(cpu_wmask), .cpu_rdata(cpu_rdata), .cpu_rbusy(cpu_rbusy),
    .cpu_wbusy(cpu_wbusy), .slv_rd(slv_rd), .slv_wr(slv_wr), .slv_rdata(slv_rdata),
    .slv_rbusy(slv_rbusy), .slv_wbusy(slv_wbusy), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [7:0]  rbusy;
    logic [7:0]  wbusy;
    logic [7:0]  e_rd;
    logic [7:0]  e_wr;
    logic        e_rb;
    logic        e_wb;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt [19];

  function automatic logic [31:0] dat(input int i);
    return (i == 6) ? 32'h1234_5678 : (32'hA000_0000 | 32'(i));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle just after the rising edge, return at the falling edge
  task automatic step(input logic [31:0] a, input logic r, input logic [3:0] m,
                      input logic [7:0] rb, input logic [7:0] wb);
    @(posedge clk);
    #1;
    cpu_addr  = a;
    cpu_rstrb = r;
    cpu_wmask = m;
    slv_rbusy = rb;
    slv_wbusy = wb;
    @(negedge clk);
  endtask

  // Internal register read; data appears the following cycle
  task automatic rd_int(input logic [1:0] off, input logic [31:0] exp, input string nm);
    step(32'h00FF_0000 | {28'd0, off, 2'b00}, 1'b1, 4'h0, slv_rbusy, slv_wbusy);
    step(32'h0000_0000, 1'b0, 4'h0, slv_rbusy, slv_wbusy);
    chk(nm, cpu_rdata, exp);
  endtask

  // Runs a transaction against a stuck slave; reports busy-high cycles,
  // strobe pulses and the first cycle that looks like ABORT
  task automatic hang(input logic [31:0] a, input logic is_wr, input int slave,
                      output int busy_n, output int strobe_n, output int abort_k);
    logic [7:0] stuck;
    stuck    = 8'(1) << slave;
    busy_n   = 0;
    strobe_n = 0;
    abort_k  = -1;
    for (int k = 0; k < 14; k++) begin
      step((k == 0) ? a : 32'd0, (k == 0) && !is_wr, ((k == 0) && is_wr) ? 4'h1 : 4'h0,
           is_wr ? 8'h00 : stuck, is_wr ? stuck : 8'h00);
      busy_n   += is_wr ? int'(cpu_wbusy) : int'(cpu_rbusy);
      strobe_n += is_wr ? int'(slv_wr[slave]) : int'(slv_rd[slave]);
      if (abort_k < 0 && k > 0 && !(is_wr ? cpu_wbusy : cpu_rbusy)) abort_k = k;
      if (!is_wr && k == 9) chk("abort_rdata", cpu_rdata, 32'hDEADBEEF);
    end
  endtask

  initial begin
    int bn, sn, ak, rb_n, rd_n;
    bit rdata_ok;

    for (int i = 0; i < N; i++) slv_rdata[32*i +: 32] = dat(i);
    //          addr          rs   wm     rbusy  wbusy  e_rd   e_wr   rb    wb    rdata
    vt[0]  = '{32'h0000_0000, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, dat(0)};
    vt[1]  = '{32'h0002_0004, 1'b1, 4'h0, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0, 1'b0, dat(0)};
    vt[2]  = '{32'h0000_0000, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, dat(1)};
    vt[3]  = '{32'h0123_0000, 1'b1, 4'h0, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, dat(1)};
    vt[4]  = '{32'h0007_0000, 1'b0, 4'h3, 8'h00, 8'h00, 8'h00, 8'h80, 1'b0, 1'b0, dat(0)};
    vt[5]  = '{32'h0005_0000, 1'b1, 4'hF, 8'h00, 8'h00, 8'h00, 8'h20, 1'b0, 1'b0, dat(0)};
    vt[6]  = '{32'h0000_0000, 1'b0, 4'h0, 8'h00, 8'h20, 8'h00, 8'h00, 1'b0, 1'b1, dat(0)};
    vt[7]  = '{32'h0000_0000, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, dat(0)};
    vt[8]  = '{32'h0003_0000, 1'b1, 4'h0, 8'h04, 8'h00, 8'h04, 8'h00, 1'b1, 1'b0, dat(0)};
    vt[9]  = '{32'h0004_0000, 1'b1, 4'h0, 8'h04, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, dat(2)};
    vt[10] = '{32'h0006_0000, 1'b1, 4'h0, 8'h00, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0, dat(2)};
    vt[11] = '{32'h0000_0000, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, dat(4)};
    vt[12] = '{32'h0007_0000, 1'b1, 4'h0, 8'h01, 8'h00, 8'h80, 8'h00, 1'b0, 1'b0, dat(4)};
    vt[13] = '{32'h0000_0000, 1'b0, 4'h0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, dat(7)};
    vt[14] = '{32'h00FF_000C, 1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, dat(7)};
    vt[15] = '{32'h0000_0000, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0};
    vt[16] = '{32'h00FF_0008, 1'b1, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0};
    vt[17] = '{32'h0000_0000, 1'b0, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0};
    vt[18] = '{32'h00FF_0004, 1'b0, 4'hF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 32'd0};

    // Reset state, with a read strobe held to show strobes are gated
    reset = 1'b1; cpu_addr = 32'd0; cpu_rstrb = 1'b1; cpu_wmask = 4'h0;
    slv_rbusy = 8'h00; slv_wbusy = 8'h00;
    #12;
    chk("rst_slv_rd", 32'(slv_rd), 32'd0);
    chk("rst_rbusy", 32'(cpu_rbusy), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_rdata", cpu_rdata, dat(0));
    @(posedge clk); #1; reset = 1'b0; cpu_rstrb = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(vt[i].addr, vt[i].rstrb, vt[i].wmask, vt[i].rbusy, vt[i].wbusy);
      chk($sformatf("v%0d_rd", i), 32'(slv_rd), 32'(vt[i].e_rd));
      chk($sformatf("v%0d_wr", i), 32'(slv_wr), 32'(vt[i].e_wr));
      chk($sformatf("v%0d_rbusy", i), 32'(cpu_rbusy), 32'(vt[i].e_rb));
      chk($sformatf("v%0d_wbusy", i), 32'(cpu_wbusy), 32'(vt[i].e_wb));
      chk($sformatf("v%0d_rdata", i), cpu_rdata, vt[i].e_rdata);
    end

    // Slave 6 read with three busy cycles
    rb_n = 0; rd_n = 0; rdata_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step((k == 0) ? 32'h0001_0010 : 32'd0, k == 0, 4'h0, (k < 3) ? 8'h40 : 8'h00, 8'h00);
      rb_n += int'(cpu_rbusy);
      rd_n += int'(slv_rd[6]);
      if (k >= 3 && cpu_rdata !== 32'h1234_5678) rdata_ok = 1'b0;
    end
    chk("s6_rbusy_cycles", 32'(rb_n), 32'd3);
    chk("s6_rd_pulses", 32'(rd_n), 32'd1);
    chk("s6_rdata_ok", 32'(rdata_ok), 32'd1);

    // First timeout: read of slave 1 stuck busy
    hang(32'h0002_0000, 1'b0, 1, bn, sn, ak);
    chk("to1_busy_cycles", 32'(bn), 32'd9);
    chk("to1_rd_pulses", 32'(sn), 32'd1);
    chk("to1_abort_cycle", 32'(ak), 32'd9);
    chk("to1_bus_err", 32'(bus_err), 32'd1);
    rd_int(2'd1, 32'h0002_0000, "to1_err_addr");
    rd_int(2'd2, 32'd1, "to1_err_count");
    rd_int(2'd0, 32'd1, "to1_err_status");

    // Second timeout: write to slave 3 stuck busy; first fault is sticky
    hang(32'h0004_0040, 1'b1, 3, bn, sn, ak);
    chk("to2_busy_cycles", 32'(bn), 32'd9);
    chk("to2_wr_pulses", 32'(sn), 32'd1);
    rd_int(2'd1, 32'h0002_0000, "to2_err_addr");
    rd_int(2'd2, 32'd2, "to2_err_count");
    rd_int(2'd0, 32'd1, "to2_err_status");

    // Clear via write to offset 0
    step(32'h00FF_0000, 1'b0, 4'hF, slv_rbusy, slv_wbusy);
    chk("clr_same_cycle", 32'(bus_err), 32'd1);
    step(32'h0000_0000, 1'b0, 4'h0, slv_rbusy, slv_wbusy);
    chk("clr_next_cycle", 32'(bus_err), 32'd0);
    rd_int(2'd2, 32'd2, "clr_err_count");

    // Third timeout after clear captures the write fault
    hang(32'h0004_0040, 1'b1, 3, bn, sn, ak);
    rd_int(2'd0, 32'd3, "to3_err_status");
    rd_int(2'd1, 32'h0004_0040, "to3_err_addr");
    rd_int(2'd2, 32'd3, "to3_err_count");

    // Reset in the middle of a busy read
    step(32'h0003_0000, 1'b1, 4'h0, 8'h04, 8'h00);
    step(32'h0000_0000, 1'b0, 4'h0, 8'h04, 8'h00);
    chk("mid_rbusy", 32'(cpu_rbusy), 32'd1);
    #2; reset = 1'b1;
    #1;
    chk("mid_rst_rbusy", 32'(cpu_rbusy), 32'd0);
    chk("mid_rst_bus_err", 32'(bus_err), 32'd0);
    chk("mid_rst_rdata", cpu_rdata, dat(0));
    chk("mid_rst_rd", 32'(slv_rd), 32'd0);
    @(posedge clk); #1; reset = 1'b0; slv_rbusy = 8'h00; slv_wbusy = 8'h00;
    rd_int(2'd2, 32'd0, "post_rst_count");
    rd_int(2'd0, 32'd0, "post_rst_status");
    step(32'h0001_0000, 1'b1, 4'h0, 8'h00, 8'h00);
    chk("post_rst_rd", 32'(slv_rd), 32'h40);
    step(32'h0000_0000, 1'b0, 4'h0, 8'h00, 8'h00);
    chk("post_rst_rdata", cpu_rdata, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so a stalled run still ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "time limit");
  end

endmodule
